// File: rtl/instr_issue_queue.sv
// instr_issue_queue: instruction FIFO in front of two_stage_pipeline.
//
// Buffers packed instructions (operand A in [31:16], operand B in [15:0]) from
// a valid/ready producer. Each issue_en cycle it issues one instruction on a
// registered output. If the queue is empty it issues a NOP bubble instead.
//
// Parameters:
//   DEPTH    queue entries (power of 2, >= 2)
//   DATA_W   instruction width
//   NOP_WORD word driven on a bubble and after reset/flush
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_instr producer word, accepted when in_ready is high
//   in_ready          !full; there is no write-through when full
//   issue_en          pipeline advances; pop head or issue a bubble
//   flush             synchronous discard of all queued words
//   instruction_out   registered, drives two_stage_pipeline.instruction_in
//   instr_valid_out   instruction_out holds a real instruction
//   count/full/empty  occupancy status
//   issued_cnt        saturating count of real issues
//   bubble_cnt        saturating count of bubbles
//
// Optional feature: define ISSUE_STATS_EN to build the issued/bubble counters.
// When it is undefined, both counter ports are tied to zero.

`timescale 1ns/1ps

module instr_issue_queue #(
  parameter int unsigned       DEPTH    = 8,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instr,
  output logic                     in_ready,
  input  logic                     issue_en,
  input  logic                     flush,
  output logic [DATA_W-1:0]        instruction_out,
  output logic                     instr_valid_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              issued_cnt,
  output logic [15:0]              bubble_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ivalid_q, ivalid_d;

  logic push;
  logic pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

  assign instruction_out = instr_q;
  assign instr_valid_out = ivalid_q;

  // Both decisions use the pre-edge occupancy, so a word is never issued in
  // the same edge it is accepted.
  assign push = in_valid && in_ready;
  assign pop  = issue_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    ivalid_d = ivalid_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      instr_d  = NOP_WORD;
      ivalid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (issue_en) begin
        if (pop) begin
          instr_d  = mem_q[rd_ptr_q];
          ivalid_d = 1'b1;
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
          instr_d  = NOP_WORD;
          ivalid_d = 1'b0;
        end
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP_WORD;
      ivalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] bubble_q;

  // A flush cycle overrides the pop, so it counts as neither an issue nor a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      bubble_q <= '0;
    end else if (!flush && issue_en) begin
      if (!empty) begin
        if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      end else begin
        if (bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      end
    end
  end

  assign issued_cnt = issued_q;
  assign bubble_cnt = bubble_q;
`else
  assign issued_cnt = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
`timescale 1ns/1ps

module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        issue_en;
  logic        flush;
  logic [31:0] instruction_out;
  logic        instr_valid_out;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] issued_cnt;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  instr_issue_queue #(
    .DEPTH    (8),
    .DATA_W   (32),
    .NOP_WORD (32'h00000000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instr        (in_instr),
    .in_ready        (in_ready),
    .issue_en        (issue_en),
    .flush           (flush),
    .instruction_out (instruction_out),
    .instr_valid_out (instr_valid_out),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .issued_cnt      (issued_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    issue_en = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] mq[$];
  logic [31:0] exp_w;
  logic        m_push, m_pop;
  int          k, cyc;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    issue_en = 1'b0;
    flush    = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_out",   instruction_out, 32'h0);
    check("rst_valid", 32'(instr_valid_out), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // Single word latency: accepted at edge N, issued at edge N+1
    in_valid = 1'b1;
    in_instr = 32'h00010002;
    issue_en = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_accept_count", 32'(count), 32'h1);
    check("lat_accept_valid", 32'(instr_valid_out), 32'h0);
    step();
    check("lat_out",   instruction_out, 32'h00010002);
    check("lat_valid", 32'(instr_valid_out), 32'h1);
    step();
    check("lat_bubble_out",   instruction_out, 32'h0);
    check("lat_bubble_valid", 32'(instr_valid_out), 32'h0);

    // Fill to full with issue held, refuse a ninth word, then drain in order
    for (int i = 0; i < 8; i++) push_idle({16'(i + 1), 16'(i + 2)});
    check("full_flag",  32'(full), 32'h1);
    check("full_ready", 32'(in_ready), 32'h0);
    check("full_count", 32'(count), 32'h8);
    check("hold_valid", 32'(instr_valid_out), 32'h0);
    push_idle(32'hFFFF0001);
    check("refuse_count", 32'(count), 32'h8);
    issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain_out%0d", i), instruction_out, {16'(i + 1), 16'(i + 2)});
      check($sformatf("drain_vld%0d", i), 32'(instr_valid_out), 32'h1);
    end
    check("drain_ready", 32'(in_ready), 32'h1);
    step();
    check("drain_bubble_out", instruction_out, 32'h0);
    check("drain_bubble_vld", 32'(instr_valid_out), 32'h0);
    check("drain_count",      32'(count), 32'h0);
    issue_en = 1'b0;

    // Continuous push with issue_en toggling 1,0,1,0; scoreboard across wrap
    k   = 0;
    cyc = 0;
    mq.delete();
    while ((k < 20 || mq.size() > 0) && cyc < 200) begin
      issue_en = (cyc % 2 == 0);
      in_valid = (k < 20);
      in_instr = 32'hA0000000 + 32'(k);
      m_push   = in_valid && (mq.size() < 8);
      m_pop    = issue_en && (mq.size() > 0);
      exp_w    = 32'h0;
      if (m_pop) exp_w = mq.pop_front();
      if (m_push) begin
        mq.push_back(in_instr);
        k++;
      end
      step();
      if (issue_en) begin
        check($sformatf("stream_out_c%0d", cyc), instruction_out, exp_w);
        check($sformatf("stream_vld_c%0d", cyc), 32'(instr_valid_out), 32'(m_pop));
      end
      check($sformatf("stream_cnt_c%0d", cyc), 32'(count), 32'(mq.size()));
      cyc++;
    end
    check("stream_done", 32'(cyc < 200), 32'h1);
    in_valid = 1'b0;
    issue_en = 1'b0;

    // Simultaneous push and pop at count 3
    for (int i = 1; i <= 3; i++) push_idle(32'hB0000000 + 32'(i));
    check("pp_pre_count", 32'(count), 32'h3);
    in_valid = 1'b1;
    in_instr = 32'hB0000004;
    issue_en = 1'b1;
    step();
    in_valid = 1'b0;
    check("pp_count", 32'(count), 32'h3);
    check("pp_out",   instruction_out, 32'hB0000001);
    check("pp_vld",   32'(instr_valid_out), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("pp_drain%0d", i), instruction_out, 32'hB0000000 + 32'(i));
    end
    step();
    check("pp_empty", 32'(empty), 32'h1);
    issue_en = 1'b0;

    // Flush with 5 queued words and a concurrent push and issue
    for (int i = 1; i <= 6; i++) push_idle(32'hC0000000 + 32'(i));
    issue_en = 1'b1;
    step();
    check("fl_pre_out",   instruction_out, 32'hC0000001);
    check("fl_pre_count", 32'(count), 32'h5);
    in_valid = 1'b1;
    in_instr = 32'h80000001;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_count", 32'(count), 32'h0);
    check("fl_out",   instruction_out, 32'h0);
    check("fl_vld",   32'(instr_valid_out), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_after_out%0d", i), instruction_out, 32'h0);
      check($sformatf("fl_after_vld%0d", i), 32'(instr_valid_out), 32'h0);
    end
    issue_en = 1'b0;

    // Reset mid-stream: queued words are lost, next issue is a bubble
    for (int i = 1; i <= 3; i++) push_idle(32'hD0000000 + 32'(i));
    issue_en = 1'b1;
    step();
    check("mrst_pre_out", instruction_out, 32'hD0000001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_out",   instruction_out, 32'h0);
    check("mrst_count", 32'(count), 32'h0);
    check("mrst_issued", 32'(issued_cnt), 32'h0);
    check("mrst_bubble", 32'(bubble_cnt), 32'h0);
    step();
    check("mrst_next_vld", 32'(instr_valid_out), 32'h0);
    issue_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Stats: 3 real issues, 2 bubbles
    for (int i = 1; i <= 3; i++) push_idle(32'hE0000000 + 32'(i));
    issue_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    issue_en = 1'b0;
`ifdef ISSUE_STATS_EN
    check("stat_issued", 32'(issued_cnt), 32'd3);
    check("stat_bubble", 32'(bubble_cnt), 32'd2);
    issue_en = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    issue_en = 1'b0;
    check("stat_bubble_sat", 32'(bubble_cnt), 32'h0000FFFF);
    check("stat_issued_kept", 32'(issued_cnt), 32'd3);
`else
    check("stat_issued_tied", 32'(issued_cnt), 32'h0);
    check("stat_bubble_tied", 32'(bubble_cnt), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Front-end stage directly upstream of two_stage_pipeline.
- Buffers packed 32-bit instructions (operand A in [31:16], operand B in [15:0]) from a producer using a valid/ready handshake.
- Issues at most one instruction per enabled cycle on a registered output that drives the pipeline's instruction_in.
- Issues a NOP bubble when the queue is empty, so the pipeline always sees a defined word.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 2.
- DATA_W, 32, instruction width.
- NOP_WORD, 32'h00000000, word driven on a bubble and after reset or flush.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_instr
- in_instr  input  DATA_W  instruction from producer
- in_ready  output  1  queue can accept a word this cycle
- issue_en  input  1  pipeline advances this cycle
- flush  input  1  synchronous discard of all queued words
- instruction_out  output  DATA_W  registered, drives two_stage_pipeline.instruction_in
- instr_valid_out  output  1  instruction_out holds a real (non-bubble) instruction
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- issued_cnt  output  16  real instructions issued (see Optional Feature)
- bubble_cnt  output  16  bubbles issued (see Optional Feature)

Behaviour:
- Reset (synchronous, highest priority):
  - wr_ptr, rd_ptr and count clear to 0.
  - instruction_out = NOP_WORD, instr_valid_out = 0.
  - Stats counters clear to 0.
- Combinational status outputs:
  - in_ready = !full. There is no write-through when full: a push is refused even if a pop happens in the same cycle.
  - full and empty are decoded from count.
- Push: when in_valid && in_ready at the edge, write in_instr to mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Pop/issue, evaluated only when issue_en = 1, using the pre-edge count:
  - If count > 0: instruction_out <= mem[rd_ptr], instr_valid_out <= 1, rd_ptr increments and wraps.
  - If count == 0: instruction_out <= NOP_WORD, instr_valid_out <= 0. This is a bubble.
- Hold: when issue_en = 0, instruction_out and instr_valid_out hold their values and nothing is popped.
- count update: count_next = count + push − pop. A simultaneous push and pop leaves count unchanged.
- Latency: a word accepted at edge N appears on instruction_out at edge N+1 at the earliest, given issue_en = 1 and the queue empty beforehand. The queue never issues a word in the same edge it is accepted.
- Ordering: strict FIFO; no reordering and no drops.
- flush:
  - Priority is below reset and above push and pop.
  - Pointers and count go to 0, instruction_out = NOP_WORD, instr_valid_out = 0.
  - A push presented in the same cycle is discarded.
  - Stats counters are not cleared.
- Wrap-around: pointers wrap with no gap. After DEPTH pushes and DEPTH pops, ptr == 0 and the queue is empty.
- Reset or flush asserted mid-stream: queued words are lost and the next issued word is a bubble.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined:
  - issued_cnt increments on every issue of a real instruction.
  - bubble_cnt increments on every issue_en cycle with an empty queue.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear only on reset.
- Undefined: both ports are tied to 16'h0000 and no counter logic is generated.

Test Plan:
- Reset, then push 32'h00010002 with issue_en = 1 -> at the next edge instruction_out = 32'h00010002, instr_valid_out = 1; one cycle later instruction_out = 32'h00000000, instr_valid_out = 0.
- With issue_en = 0, push 8 words 32'h00010002..32'h00080009 -> full = 1, in_ready = 0; a 9th word 32'hFFFF0001 is refused. Raise issue_en -> the 8 words emerge in order, then bubbles; count returns to 0.
- Push continuously while issue_en toggles 1,0,1,0 for 20 words -> output order matches input order, including across pointer wrap.
- Simultaneous push and pop at count = 3 -> count stays 3, and the head word is issued.
- Queue holding 5 words; assert flush together with in_valid for a push of 32'h80000001 -> count = 0, instruction_out = NOP_WORD, and 32'h80000001 is never issued.
- With ISSUE_STATS_EN defined: issue 3 real words and 2 bubbles -> issued_cnt = 3, bubble_cnt = 2. Force 70000 bubbles -> bubble_cnt saturates at 16'hFFFF.
